// File: rtl/ppu_hazard_sequencer.sv
// PPU pipeline sequencer: load-use bubble insertion, freeze handling and
// operand forwarding selection from EX/MEM/WB destination tracking.
module ppu_hazard_sequencer #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_rf_enable,
  input  logic                   id_load_instr,
  input  logic                   freeze,
  output logic                   pc_le,
  output logic                   npc_le,
  output logic                   ifid_le,
  output logic                   nop_sel,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [1:0]             seq_state
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_BUBBLE = 2'b01;
  localparam logic [1:0] ST_FROZEN = 2'b10;

  // Load flag is only consulted in EX, so MEM/WB carry just dest and rf_en.
  logic [REG_ADDR_W-1:0]  r_ex_dest, r_mem_dest, r_wb_dest;
  logic                   r_ex_rf, r_mem_rf, r_wb_rf;
  logic                   r_ex_ld;
  logic [1:0]             r_state;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic       w_load_use;
  logic       w_le;
  logic       w_nop;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic [1:0] w_state_nxt;

  function automatic logic [1:0] fwd_src(
    input logic [REG_ADDR_W-1:0] r,
    input logic [REG_ADDR_W-1:0] ex_d,
    input logic                  ex_rf,
    input logic                  ex_ld,
    input logic [REG_ADDR_W-1:0] mem_d,
    input logic                  mem_rf,
    input logic [REG_ADDR_W-1:0] wb_d,
    input logic                  wb_rf
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (r == '0)
      sel = 2'b00;
    else if (ex_rf && ex_d == r)
      sel = ex_ld ? 2'b00 : 2'b01;
    else if (mem_rf && mem_d == r)
      sel = 2'b10;
    else if (wb_rf && wb_d == r)
      sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    w_load_use = r_ex_ld && r_ex_rf && (r_ex_dest != '0) &&
                 ((id_uses_rs && id_rs == r_ex_dest) ||
                  (id_uses_rt && id_rt == r_ex_dest));
    w_fwd_a = fwd_src(id_rs, r_ex_dest, r_ex_rf, r_ex_ld,
                      r_mem_dest, r_mem_rf, r_wb_dest, r_wb_rf);
    w_fwd_b = fwd_src(id_rt, r_ex_dest, r_ex_rf, r_ex_ld,
                      r_mem_dest, r_mem_rf, r_wb_dest, r_wb_rf);
  end

  always_comb begin
    w_le  = 1'b1;
    w_nop = 1'b0;
    if (reset) begin
      w_le  = 1'b0;
      w_nop = 1'b1;
    end else if (freeze) begin
      w_le  = 1'b0;
    end else if (w_load_use) begin
      w_le  = 1'b0;
      w_nop = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN, ST_BUBBLE, ST_FROZEN: begin
        if (freeze)
          w_state_nxt = ST_FROZEN;
        else if (w_load_use)
          w_state_nxt = ST_BUBBLE;
        else
          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_dest   <= '0;
      r_ex_rf     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_mem_dest  <= '0;
      r_mem_rf    <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_rf     <= 1'b0;
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      if (!freeze) begin
        r_ex_dest  <= w_nop ? '0 : id_dest;
        r_ex_rf    <= w_nop ? 1'b0 : id_rf_enable;
        r_ex_ld    <= w_nop ? 1'b0 : id_load_instr;
        r_mem_dest <= r_ex_dest;
        r_mem_rf   <= r_ex_rf;
        r_wb_dest  <= r_mem_dest;
        r_wb_rf    <= r_mem_rf;
      end
      if (!w_le && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      r_state <= w_state_nxt;
    end
  end

  assign pc_le       = w_le;
  assign npc_le      = w_le;
  assign ifid_le     = w_le;
  assign nop_sel     = w_nop;
  assign fwd_a_sel   = reset ? 2'b00 : w_fwd_a;
  assign fwd_b_sel   = reset ? 2'b00 : w_fwd_b;
  assign stall_count = r_stall_cnt;
  assign seq_state   = r_state;

endmodule

// File: doc/ppu_hazard_sequencer.md
Name: ppu_hazard_sequencer

Overview:
- Pipeline sequencer for the PPU: tracks destination/load info for instructions in EX, MEM and WB.
- Drives the PC/nPC/IF-ID load enables and the ID/EX control-word NOP mux (zeroes the 24-bit control word), and selects the operand forwarding sources.
- Inserts a one-cycle bubble on load-use hazards and honours an external pipeline freeze.
- Sits beside the control unit; its ID-side inputs come from the decoded instruction and control word.

Parameters:
- REG_ADDR_W, 5, register index width.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  REG_ADDR_W  rs index of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt index of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_dest  in  REG_ADDR_W  resolved destination index: rd, rt or 31 per Destination_Register.
- id_rf_enable  in  1  ID_RF_Enable of the ID instruction.
- id_load_instr  in  1  ID instruction is a memory load, i.e. ID_MEM_Enable & ~ID_MEM_RW & ID_Load_Instr.
- freeze  in  1  external hold request, e.g. data-memory wait.
- pc_le  out  1  PC load enable.
- npc_le  out  1  nPC load enable.
- ifid_le  out  1  IF/ID register load enable.
- nop_sel  out  1  forces an all-zero control word into ID/EX.
- fwd_a_sel  out  2  rs operand source: 00 RF, 01 EX, 10 MEM, 11 WB.
- fwd_b_sel  out  2  rt operand source, same encoding.
- stall_count  out  STALL_CNT_W  cycles with pc_le=0 since reset, saturating.
- seq_state  out  2  debug: 00 RUN, 01 BUBBLE, 10 FROZEN.

Behaviour:
- Tracking registers: {dest, rf_en, load} for each of EX, MEM and WB.
- Each unfrozen edge: EX takes the ID fields (all zero if nop_sel=1), MEM takes EX, WB takes MEM.
- On a freeze edge all tracking registers hold.
- A stage "writes r" iff its rf_en=1, dest==r and r!=0.
- load_use (combinational): EX load=1, EX rf_en=1, EX dest!=0, and (id_uses_rs & id_rs==EX dest | id_uses_rt & id_rt==EX dest).
- Outputs, combinational from the registers and inputs:
  - freeze=1: pc_le=npc_le=ifid_le=0, nop_sel=0. Freeze has priority over load_use.
  - else load_use=1: pc_le=npc_le=ifid_le=0, nop_sel=1 (bubble).
  - else: all LEs=1, nop_sel=0.
- Forwarding, per operand, evaluated every cycle including stalls:
  - Priority EX > MEM > WB.
  - An EX match with EX load=1 is not forwarded; that case is covered by load_use.
  - Otherwise 00. Register 0 always yields 00.
- FSM, seq_state registered:
  - RUN: next state is FROZEN if freeze, else BUBBLE if load_use, else RUN.
  - BUBBLE: same transition rules. load_use cannot re-assert for the same ID instruction because EX now holds the NOP.
  - FROZEN: stays FROZEN while freeze=1. On release, next state follows the same rules from the current registers. A load held in EX across the freeze still produces exactly one bubble after release.
- stall_count: increments on every edge where pc_le=0 and reset=0; holds at all-ones.
- Reset, while asserted and on the edge:
  - tracking registers cleared, seq_state=RUN, stall_count=0.
  - outputs forced to pc_le=npc_le=ifid_le=0, nop_sel=1, fwd_*_sel=00.
  - the first cycle after deassertion behaves as RUN with an empty pipeline.
- Reset mid-stall or mid-freeze: discards all in-flight tracking; no bubble is pending after reset.
- Latency: hazard response in the same cycle the ID instruction is presented; exactly one bubble per load-use.

Test Plan:
- Reset held 2 cycles -> pc_le=0, nop_sel=1, fwd_a_sel=fwd_b_sel=00, stall_count=0, seq_state=00; cycle after release -> pc_le=1, nop_sel=0.
- ADDIU dest=5 (rf_en=1), then SUBU rs=5 uses_rs=1 on consecutive cycles -> fwd_a_sel=01. Same reader placed 2 or 3 instructions later -> fwd_a_sel=10 or 11. No stall in any case.
- LBU dest=2 (load=1), then SUBU rt=2 -> one cycle with pc_le=npc_le=ifid_le=0, nop_sel=1, seq_state next 01, stall_count=1. Next cycle fwd_b_sel=10, pc_le=1.
- Writer dest=0 rf_en=1, then reader rs=0 -> fwd_a_sel=00, no stall. EX and MEM both writing r7, reader rt=7 -> fwd_b_sel=01.
- Load dest=3 in EX with a reader of r3 in ID, freeze=1 for 3 cycles -> LEs=0, nop_sel=0, seq_state=10, tracking held, stall_count=3. After release exactly one bubble -> stall_count=4.
- STALL_CNT_W=4, freeze held 20 cycles -> stall_count saturates at 15. Reset asserted during the freeze -> stall_count=0, seq_state=00.
